// File: rtl/dmem_access_ctrl_pkg.sv
// Shared CPU package: opcode constants, data-memory FSM encoding and defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_access_ctrl_pkg;

  // Major opcodes of the load/store instructions steered to the MEM stage
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Data-memory access controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  // Default number of BUSY cycles allowed before giving up on the memory
  localparam int DMEM_TIMEOUT_DEF = 16;

  // Width of the wait counter; never below one bit so TIMEOUT=1 still builds
  function automatic int dmem_cnt_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side and memory-side signals of the data-memory access controller.
// Latency: n/a (wiring only).
// Backpressure: stall_o from the controller freezes the pipeline side.
interface dmem_access_ctrl_if #(
  parameter int DATA_W = 32
);

  // pipeline side
  logic              MemRead_i;
  logic              MemWrite_i;
  logic [DATA_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              stall_o;
  logic [DATA_W-1:0] rdata_o;

  // memory side
  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  // error reporting
  logic              err_clr_i;
  logic              err_o;

  // controller view
  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, wdata_i,
    input  mem_ack_i, mem_rdata_i, err_clr_i,
    output stall_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

  // pipeline + memory view (drives the controller)
  modport master (
    output MemRead_i, MemWrite_i, addr_i, wdata_i,
    output mem_ack_i, mem_rdata_i, err_clr_i,
    input  stall_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: IDLE/BUSY/DONE FSM with wait-timeout.
// Latency: 2 stall cycles for a zero-wait memory, +1 per extra wait cycle; TIMEOUT+1 on timeout.
// Backpressure: stall_o freezes the whole pipeline while a request is pending or in flight.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DMEM_TIMEOUT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dmem_access_ctrl_if.slave  bus
);

  localparam int                CNT_W    = dmem_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  dmem_state_e       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_acc_req;
  logic              w_timeout;

  assign w_acc_req = bus.MemRead_i | bus.MemWrite_i;

  // Last permitted BUSY cycle passed without an ack; an ack on that cycle takes priority
  assign w_timeout = (r_state == ST_BUSY) && !bus.mem_ack_i && (r_cnt == CNT_LAST);

  // Access FSM, wait counter, latched request fields, load data and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc_req) begin
            // read+write together is a store
            r_addr  <= bus.addr_i;
            r_wdata <= bus.wdata_i;
            r_we    <= bus.MemWrite_i;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.mem_ack_i) begin
            if (!r_we) begin
              r_rdata <= bus.mem_rdata_i;
            end
            r_req   <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            // give the pipeline a defined zero instead of stale data
            r_rdata <= '0;
            r_req   <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // pipeline advances on this edge, so never re-accept the same access here
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase

      // set beats clear
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (bus.err_clr_i) begin
        r_err <= 1'b0;
      end
    end
  end

  // Stall asserts in the same cycle a request shows up, and for the whole BUSY phase
  assign bus.stall_o     = ((r_state == ST_IDLE) && w_acc_req) || (r_state == ST_BUSY);
  assign bus.mem_req_o   = r_req;
  assign bus.mem_we_o    = r_we;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.rdata_o     = r_rdata;
  assign bus.err_o       = r_err;

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, data and address width.
REQ-002 Parameter: TIMEOUT, 16, maximum BUSY cycles spent waiting for mem_ack_i.
REQ-003 Port: clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_i  in  1  asynchronous, active-high reset.
REQ-005 Port: MemRead_i  in  1  MEM-stage load request from pipeline control.
REQ-006 Port: MemWrite_i  in  1  MEM-stage store request from pipeline control.
REQ-007 Port: addr_i  in  DATA_W  MEM-stage ALU result (byte address).
REQ-008 Port: wdata_i  in  DATA_W  MEM-stage store data.
REQ-009 Port: stall_o  out  1  freeze PC and all pipeline registers.
REQ-010 Port: rdata_o  out  DATA_W  load data to MEM/WB register.
REQ-011 Port: mem_req_o  out  1  request to data memory.
REQ-012 Port: mem_we_o  out  1  1 = write, 0 = read.
REQ-013 Port: mem_addr_o  out  DATA_W  latched address.
REQ-014 Port: mem_wdata_o  out  DATA_W  latched store data.
REQ-015 Port: mem_ack_i  in  1  memory completion, one-cycle pulse.
REQ-016 Port: mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i.
REQ-017 Port: err_clr_i  in  1  clear sticky timeout flag.
REQ-018 Port: err_o  out  1  sticky timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, BUSY, DONE.
REQ-020 IDLE: if MemRead_i or MemWrite_i, latch addr_i, wdata_i and we = MemWrite_i into mem_* registers, clear timeout counter, go to BUSY; otherwise stay in IDLE.
REQ-021 MemRead_i and MemWrite_i both high SHALL be treated as a write.
REQ-022 BUSY: mem_req_o = 1; mem_addr_o, mem_wdata_o, mem_we_o stable for the entire state.
REQ-023 BUSY with mem_ack_i = 1: for a read, capture mem_rdata_i into rdata_o; go to DONE.
REQ-024 BUSY without ack: counter increments; when counter = TIMEOUT-1 and no ack, set err_o, load rdata_o = 0, go to DONE.
REQ-025 Ack and timeout in the same cycle: ack wins, err_o unchanged.
REQ-026 DONE: mem_req_o = 0, stall_o = 0 for exactly one cycle; unconditionally return to IDLE (the pipeline advances on this edge, so the same access is never reissued).
REQ-027 stall_o = (IDLE and (MemRead_i or MemWrite_i)) or BUSY; combinational from state and inputs; no other path.
REQ-028 Zero-wait memory (ack on first BUSY cycle) SHALL give exactly 2 stall cycles per access; each extra wait cycle adds one.
REQ-029 mem_ack_i outside BUSY SHALL be ignored.
REQ-030 rdata_o SHALL hold its value until the next completed read or timeout.
REQ-031 Stores SHALL leave rdata_o unchanged.
REQ-032 err_o is cleared by err_clr_i in any state; if set and clear occur in the same cycle, set wins.
REQ-033 Timeout counter width SHALL be clog2(TIMEOUT); no wrap past TIMEOUT-1.

Reset
REQ-034 rst_i high SHALL immediately force IDLE, with stall_o (given no request), mem_req_o, mem_we_o, err_o, counter, mem_addr_o, mem_wdata_o and rdata_o all 0.
REQ-035 Reset during BUSY SHALL abandon the access; a late mem_ack_i is ignored.

Structure
REQ-036 State encodings and the default TIMEOUT SHALL reside in the shared CPU package, beside the opcode constants.
REQ-037 No sub-module; a single FSM plus counter.

Verification
REQ-038 Load, addr 0x10, ack on first BUSY cycle with rdata 0xDEADBEEF -> stall high 2 cycles, rdata_o = 0xDEADBEEF, err_o = 0.
REQ-039 Store, addr 0x20, data 0x12345678, ack after 3 wait cycles -> mem_we_o = 1, address and data stable through BUSY, stall high 5 cycles, rdata_o unchanged.
REQ-040 Load with no ack, TIMEOUT = 16 -> stall high 17 cycles, err_o = 1, rdata_o = 0; err_clr_i pulse -> err_o = 0.
REQ-041 Back-to-back loads at 0x4 and 0x8 -> exactly one DONE cycle between accesses; each issues exactly one request.
REQ-042 rst_i asserted mid-BUSY, then ack one cycle after release -> IDLE, mem_req_o = 0, ack ignored, rdata_o = 0.
REQ-043 Ack and timeout on the same cycle, plus a stray ack in IDLE -> data captured, err_o = 0, stray ack changes no state.
